// File: rtl/mips_pkg.sv
// Shared constants and types for the data-memory arbitration slice.
package mips_pkg;

  localparam int AW       = 7;
  localparam int DW       = 32;
  localparam int PORT_CPU = 0;
  localparam int PORT_DBG = 1;

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rr_lock_arb2.sv
// Two-requester round-robin arbiter with a bounded lock (burst) mode.
//   state  | meaning
//   ARB    | free arbitration, round-robin on ties
//   LOCKED | only the owner may be granted, until it drops lock or hits LOCK_MAX beats
module rr_lock_arb2
  import mips_pkg::*;
#(
  parameter int LOCK_MAX = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] valid,
  input  logic [1:0] lock,
  input  logic       accept,
  output logic [1:0] grant,
  output logic       locked,
  output logic       owner
);

  localparam int CW = $clog2(LOCK_MAX + 1);

  arb_state_e    state, state_nxt;
  logic          last_grant, last_nxt;
  logic          owner_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          gidx;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ARB;
      last_grant <= 1'b1;
      owner      <= 1'b0;
      cnt        <= '0;
    end else begin
      state      <= state_nxt;
      last_grant <= last_nxt;
      owner      <= owner_nxt;
      cnt        <= cnt_nxt;
    end
  end

  always_comb begin
    grant = 2'b00;
    if (rst_n) begin
      if (state == LOCKED) begin
        grant[owner] = valid[owner];
      end else if (valid == 2'b11) begin
        grant[last_grant ? PORT_CPU : PORT_DBG] = 1'b1;
      end else begin
        grant = valid;
      end
    end
  end

  assign gidx   = grant[PORT_DBG];
  assign locked = (state == LOCKED);

  always_comb begin
    state_nxt = state;
    last_nxt  = last_grant;
    owner_nxt = owner;
    cnt_nxt   = cnt;
    if (accept) begin
      if (state == ARB) begin
        last_nxt = gidx;
        // A one-beat lock limit can never hold the grant, so it never enters LOCKED.
        if (lock[gidx] && (LOCK_MAX > 1)) begin
          state_nxt = LOCKED;
          owner_nxt = gidx;
          cnt_nxt   = CW'(1);
        end
      end else if (!lock[owner] || (cnt == CW'(LOCK_MAX - 1))) begin
        state_nxt = ARB;
        last_nxt  = owner;
        cnt_nxt   = '0;
      end else begin
        cnt_nxt = cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: CPU and debug/loader share one single-port SRAM.
// Commands are registered onto the SRAM pins; read data returns two cycles after accept.
module dmem_arbiter
  import mips_pkg::*;
#(
  parameter int AW       = mips_pkg::AW,
  parameter int DW       = mips_pkg::DW,
  parameter int LOCK_MAX = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [1:0]    req_valid,
  output logic [1:0]    req_ready,
  input  logic [1:0]    req_we,
  input  logic [1:0]    req_lock,
  input  logic [AW-1:0] req_addr0,
  input  logic [AW-1:0] req_addr1,
  input  logic [DW-1:0] req_wdata0,
  input  logic [DW-1:0] req_wdata1,
  output logic [1:0]    rsp_valid,
  output logic [DW-1:0] rsp_rdata,
  output logic          CEN,
  output logic          WEN,
  output logic          OEN,
  output logic [AW-1:0] A,
  output logic [DW-1:0] Data2Mem,
  input  logic [DW-1:0] ReadDataMem
);

  logic [1:0] grant;
  logic       locked;
  logic       owner;
  logic       accept;
  logic       sel;
  logic [1:0] rd_pend;
  logic [1:0] rsp_q;

  rr_lock_arb2 #(
    .LOCK_MAX(LOCK_MAX)
  ) u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .valid (req_valid),
    .lock  (req_lock),
    .accept(accept),
    .grant (grant),
    .locked(locked),
    .owner (owner)
  );

  assign req_ready = grant;
  assign accept    = |(req_valid & grant);
  assign sel       = locked ? owner : grant[PORT_DBG];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      CEN      <= 1'b1;
      WEN      <= 1'b1;
      OEN      <= 1'b1;
      A        <= '0;
      Data2Mem <= '0;
      rd_pend  <= 2'b00;
      rsp_q    <= 2'b00;
    end else begin
      rd_pend <= 2'b00;
      rsp_q   <= rd_pend;
      if (accept) begin
        CEN <= 1'b0;
        A   <= sel ? req_addr1 : req_addr0;
        WEN <= ~req_we[sel];
        OEN <= req_we[sel];
        if (req_we[sel]) begin
          Data2Mem <= sel ? req_wdata1 : req_wdata0;
        end else begin
          rd_pend[sel] <= 1'b1;
        end
      end else begin
        CEN <= 1'b1;
        WEN <= 1'b1;
        OEN <= 1'b1;
      end
    end
  end

  // Gating keeps a response registered just before reset from leaking out during it.
  assign rsp_valid = rst_n ? rsp_q : 2'b00;
  assign rsp_rdata = ReadDataMem;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural SRAM and a cycle-level reference model.
module tb_dmem_arbiter;

  localparam int AW       = 7;
  localparam int DW       = 32;
  localparam int LOCK_MAX = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    req_valid, req_ready, req_we, req_lock;
  logic [AW-1:0] req_addr0, req_addr1;
  logic [DW-1:0] req_wdata0, req_wdata1;
  logic [1:0]    rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          CEN, WEN, OEN;
  logic [AW-1:0] A;
  logic [DW-1:0] Data2Mem, ReadDataMem;

  int checks   = 0;
  int failures = 0;

  dmem_arbiter #(.AW(AW), .DW(DW), .LOCK_MAX(LOCK_MAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_lock(req_lock),
    .req_addr0(req_addr0), .req_addr1(req_addr1),
    .req_wdata0(req_wdata0), .req_wdata1(req_wdata1),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .CEN(CEN), .WEN(WEN), .OEN(OEN), .A(A), .Data2Mem(Data2Mem),
    .ReadDataMem(ReadDataMem)
  );

  always #5 clk = ~clk;

  // Behavioural SRAM driven only by the DUT pins.
  logic [DW-1:0] sram [0:(1<<AW)-1];
  logic [DW-1:0] sram_rd;
  always @(posedge clk) begin
    if (!CEN) begin
      if (!WEN) sram[A] <= Data2Mem;
      else if (!OEN) sram_rd <= sram[A];
    end
  end
  assign ReadDataMem = sram_rd;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: arbitration rules, expected pin values, response pipeline, memory image.
  logic [DW-1:0] mem_m [0:(1<<AW)-1];
  bit            m_on = 0;
  bit            m_locked;
  int            m_owner, m_last, m_cnt;
  logic          e_cen, e_wen, e_oen;
  logic [AW-1:0] e_a;
  logic [DW-1:0] e_d;
  logic [1:0]    pn_v, px_v;
  logic [DW-1:0] pn_d, px_d;
  logic [1:0]    m_g;
  int            m_idx;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wd;
  logic          m_we, m_lk;

  function automatic logic [1:0] model_grant();
    logic [1:0] g;
    g = 2'b00;
    if (m_locked) begin
      if (req_valid[m_owner]) g = (m_owner == 1) ? 2'b10 : 2'b01;
    end else if (req_valid == 2'b11) begin
      g = (m_last == 1) ? 2'b01 : 2'b10;
    end else begin
      g = req_valid;
    end
    return g;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("model_ready_in_reset", req_ready, 2'b00);
      chk("model_rsp_in_reset", rsp_valid, 2'b00);
      m_locked = 0; m_owner = 0; m_last = 1; m_cnt = 0;
      e_cen = 1; e_wen = 1; e_oen = 1; e_a = '0; e_d = '0;
      pn_v = 2'b00; px_v = 2'b00; pn_d = '0; px_d = '0;
      m_on = 1;
    end else if (m_on) begin
      chk("model_CEN", CEN, e_cen);
      chk("model_WEN", WEN, e_wen);
      chk("model_OEN", OEN, e_oen);
      chk("model_A", A, e_a);
      chk("model_Data2Mem", Data2Mem, e_d);
      chk("model_rsp_valid", rsp_valid, pn_v);
      if (pn_v != 2'b00) chk("model_rsp_rdata", rsp_rdata, pn_d);
      m_g = model_grant();
      chk("model_ready", req_ready, m_g);
      pn_v = px_v; pn_d = px_d; px_v = 2'b00;
      if (m_g != 2'b00) begin
        m_idx  = m_g[1] ? 1 : 0;
        m_addr = m_idx ? req_addr1 : req_addr0;
        m_wd   = m_idx ? req_wdata1 : req_wdata0;
        m_we   = req_we[m_idx];
        m_lk   = req_lock[m_idx];
        e_cen = 0; e_a = m_addr; e_wen = !m_we; e_oen = m_we;
        if (m_we) begin
          e_d = m_wd;
          mem_m[m_addr] = m_wd;
        end else begin
          px_v = m_idx ? 2'b10 : 2'b01;
          px_d = mem_m[m_addr];
        end
        if (!m_locked) begin
          m_last = m_idx;
          if (m_lk) begin m_locked = 1; m_owner = m_idx; m_cnt = 1; end
        end else if (!m_lk) begin
          m_locked = 0; m_last = m_owner;
        end else begin
          m_cnt++;
          if (m_cnt >= LOCK_MAX) begin m_locked = 0; m_last = m_owner; end
        end
      end else begin
        e_cen = 1; e_wen = 1; e_oen = 1;
      end
    end
  end

  task automatic drive(input logic [1:0] v, input logic [1:0] we, input logic [1:0] lk,
                       input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                       input logic [DW-1:0] d0, input logic [DW-1:0] d1);
    req_valid = v; req_we = we; req_lock = lk;
    req_addr0 = a0; req_addr1 = a1; req_wdata0 = d0; req_wdata1 = d1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ready_step(input string name, input logic [1:0] exp);
    @(negedge clk);
    chk(name, req_ready, exp);
    tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("ready_during_reset", req_ready, 2'b00);
      tick();
    end
    rst_n = 1'b1;
  endtask

  logic [1:0] tie_exp [4];

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      sram[i]  = 32'h5A5A_0000 ^ (i * 32'h0101_0101);
      mem_m[i] = 32'h5A5A_0000 ^ (i * 32'h0101_0101);
    end
    sram[5]  = 32'h1234_5678;
    mem_m[5] = 32'h1234_5678;
    tie_exp[0] = 2'b01; tie_exp[1] = 2'b10; tie_exp[2] = 2'b01; tie_exp[3] = 2'b10;
    drive(2'b00, 2'b00, 2'b00, '0, '0, '0, '0);
    rst_n = 1'b0;
    tick();
    do_reset();

    // Single CPU read of address 5.
    drive(2'b01, 2'b00, 2'b00, 7'h05, 7'h00, '0, '0);
    ready_step("read_ready", 2'b01);
    drive(2'b00, 2'b00, 2'b00, 7'h05, 7'h00, '0, '0);
    @(negedge clk);
    chk("read_CEN", CEN, 1'b0);
    chk("read_WEN", WEN, 1'b1);
    chk("read_OEN", OEN, 1'b0);
    chk("read_A", A, 7'h05);
    tick();
    @(negedge clk);
    chk("read_rsp_valid", rsp_valid, 2'b01);
    chk("read_rsp_rdata", rsp_rdata, 32'h1234_5678);
    tick();

    // Round-robin tie straight after reset: CPU first.
    do_reset();
    drive(2'b11, 2'b00, 2'b00, 7'h0A, 7'h14, '0, '0);
    for (int i = 0; i < 4; i++) ready_step("tie_grant", tie_exp[i]);
    drive(2'b00, 2'b00, 2'b00, 7'h0A, 7'h14, '0, '0);
    repeat (3) tick();

    // Lock: one CPU beat so debug wins the tie, then a 4-beat locked debug write burst.
    drive(2'b01, 2'b00, 2'b00, 7'h07, 7'h00, '0, '0);
    ready_step("pre_lock_cpu", 2'b01);
    for (int i = 0; i < 4; i++) begin
      drive(2'b11, 2'b10, (i < 3) ? 2'b10 : 2'b00, 7'h07, AW'(i), '0, 32'hA000_0000 + i);
      ready_step("lock_grant_dbg", 2'b10);
    end
    drive(2'b11, 2'b00, 2'b00, 7'h07, 7'h09, '0, '0);
    ready_step("lock_release_cpu", 2'b01);

    // Forced release after LOCK_MAX locked beats.
    for (int i = 0; i < 9; i++) begin
      drive(2'b11, 2'b10, 2'b10, 7'h07, AW'(16 + i), '0, 32'hB000_0000 + i);
      ready_step("forced_release", (i < LOCK_MAX) ? 2'b10 : 2'b01);
    end
    drive(2'b00, 2'b00, 2'b00, 7'h07, 7'h00, '0, '0);
    repeat (3) tick();

    // Owner idles while locked: CPU stays blocked, counter holds.
    for (int i = 0; i < 2; i++) begin
      drive(2'b11, 2'b10, 2'b10, 7'h07, AW'(32 + i), '0, 32'hC000_0000 + i);
      ready_step("idle_pre_dbg", 2'b10);
    end
    drive(2'b01, 2'b10, 2'b10, 7'h07, 7'h00, '0, '0);
    for (int i = 0; i < 5; i++) ready_step("idle_cpu_blocked", 2'b00);
    for (int i = 2; i < 9; i++) begin
      drive(2'b11, 2'b10, 2'b10, 7'h07, AW'(32 + i), '0, 32'hC000_0000 + i);
      ready_step("idle_resume", (i < LOCK_MAX) ? 2'b10 : 2'b01);
    end

    // Read back a word written during the lock burst.
    drive(2'b01, 2'b00, 2'b00, 7'h02, 7'h00, '0, '0);
    ready_step("readback_ready", 2'b01);
    drive(2'b00, 2'b00, 2'b00, 7'h02, 7'h00, '0, '0);
    tick();
    @(negedge clk);
    chk("readback_valid", rsp_valid, 2'b01);
    chk("readback_rdata", rsp_rdata, 32'hA000_0002);
    tick();

    // Reset one cycle after a read is accepted: the response must never appear.
    drive(2'b01, 2'b00, 2'b00, 7'h05, 7'h00, '0, '0);
    ready_step("rst_read_ready", 2'b01);
    drive(2'b01, 2'b00, 2'b00, 7'h05, 7'h00, '0, '0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_ready", req_ready, 2'b00);
    chk("rst_rsp_n1", rsp_valid, 2'b00);
    tick();
    @(negedge clk);
    chk("rst_CEN", CEN, 1'b1);
    chk("rst_rsp_n2", rsp_valid, 2'b00);
    tick();
    drive(2'b00, 2'b00, 2'b00, 7'h00, 7'h00, '0, '0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_no_rsp", rsp_valid, 2'b00);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
